// File: rtl/stereo_pkg.sv
// Shared widths, the (cost, idx) pair type and popcount for the census disparity pipeline.
package stereo_pkg;

  localparam int CEN_W = 8;
  localparam int COST_W = 4;
  localparam logic [COST_W-1:0] COST_MASK = 4'd15;
  localparam int COORD_W = 10;
  // Wide enough for the largest supported candidate count (64).
  localparam int IDX_W = 6;

  typedef struct packed {
    logic [COST_W-1:0] cost;
    logic [IDX_W-1:0]  idx;
  } disp_pair_t;

  function automatic logic [COST_W-1:0] popcount8(input logic [CEN_W-1:0] v);
    logic [COST_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < CEN_W; i++) begin
      sum = sum + {{(COST_W-1){1'b0}}, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/disp_min2.sv
// One registered node of the disparity min tree: keeps the cheaper of two (cost, idx) pairs.
module disp_min2
  import stereo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [COST_W-1:0] a_cost,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [COST_W-1:0] b_cost,
  input  logic [IDX_W-1:0]  b_idx,
  output logic [COST_W-1:0] y_cost,
  output logic [IDX_W-1:0]  y_idx
);

  // Input a always covers the lower disparities, so a strict less-than resolves ties toward a.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_cost <= '0;
      y_idx  <= '0;
    end else if (b_cost < a_cost) begin
      y_cost <= b_cost;
      y_idx  <= b_idx;
    end else begin
      y_cost <= a_cost;
      y_idx  <= a_idx;
    end
  end

endmodule

// File: rtl/census_disparity.sv
// Winner-take-all census disparity: Hamming costs over NUM_DISP candidates, then a registered min tree.
// Defining CENSUS_DISP_COST_OUT_EN adds the out_cost port carrying the winning cost.
module census_disparity
  import stereo_pkg::*;
#(
  parameter int NUM_DISP = 16,
  parameter int ROW_SZ   = 320,
  parameter int COL_SZ   = 240
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_l_val,
  input  logic [7:0]                  in_r_val,
  input  logic [9:0]                  in_x,
  input  logic [9:0]                  in_y,
  input  logic                        is_in_val,
  output logic [$clog2(NUM_DISP)-1:0] out_disp,
  output logic [9:0]                  out_x,
  output logic [9:0]                  out_y,
`ifdef CENSUS_DISP_COST_OUT_EN
  output logic [3:0]                  out_cost,
`endif
  output logic                        is_out_val
);

  localparam int K = $clog2(NUM_DISP);

  if (ROW_SZ > (1 << COORD_W) || COL_SZ > (1 << COORD_W) ||
      NUM_DISP < 2 || NUM_DISP > 64 || (1 << K) != NUM_DISP) begin : g_param_check
    $error("census_disparity: unsupported NUM_DISP/ROW_SZ/COL_SZ");
  end

  logic [CEN_W-1:0]  win_reg [1:NUM_DISP-1];
  logic [CEN_W-1:0]  win     [0:NUM_DISP-1];
  logic [COST_W-1:0] leaf_cost_reg [0:NUM_DISP-1];

  // Heap-ordered tree: node 1 is the root, leaves sit at NUM_DISP + d.
  logic [COST_W-1:0] node_cost [1:2*NUM_DISP-1];
  logic [IDX_W-1:0]  node_idx  [1:2*NUM_DISP-1];

  logic [COORD_W-1:0] x_pipe_reg [0:K];
  logic [COORD_W-1:0] y_pipe_reg [0:K];
  logic [K:0]         vld_pipe_reg;

  assign win[0] = in_r_val;

  for (genvar gi = 1; gi < NUM_DISP; gi++) begin : g_win
    assign win[gi] = win_reg[gi];
  end

  // Window advances per valid pixel, so entry d is the right code d valid pixels back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 1; d < NUM_DISP; d++) win_reg[d] <= '0;
    end else if (is_in_val) begin
      win_reg[1] <= in_r_val;
      for (int d = 2; d < NUM_DISP; d++) win_reg[d] <= win_reg[d-1];
    end
  end

  // Candidates reaching left of column 0 are forced to the mask cost so they never win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < NUM_DISP; d++) leaf_cost_reg[d] <= '0;
    end else begin
      for (int d = 0; d < NUM_DISP; d++) begin
        leaf_cost_reg[d] <= (COORD_W'(d) > in_x) ? COST_MASK
                                                 : popcount8(in_l_val ^ win[d]);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DISP; gi++) begin : g_leaf
    assign node_cost[NUM_DISP+gi] = leaf_cost_reg[gi];
    assign node_idx[NUM_DISP+gi]  = IDX_W'(gi);
  end

  for (genvar gi = 1; gi < NUM_DISP; gi++) begin : g_tree
    disp_min2 u_min (
      .clk    (clk),
      .reset  (reset),
      .a_cost (node_cost[2*gi]),
      .a_idx  (node_idx[2*gi]),
      .b_cost (node_cost[2*gi+1]),
      .b_idx  (node_idx[2*gi+1]),
      .y_cost (node_cost[gi]),
      .y_idx  (node_idx[gi])
    );
  end

  // Coordinates and valid ride alongside: slot 0 pairs with the cost stage, slot K with the root.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j <= K; j++) begin
        x_pipe_reg[j] <= '0;
        y_pipe_reg[j] <= '0;
      end
      vld_pipe_reg <= '0;
    end else begin
      x_pipe_reg[0] <= in_x;
      y_pipe_reg[0] <= in_y;
      for (int j = 1; j <= K; j++) begin
        x_pipe_reg[j] <= x_pipe_reg[j-1];
        y_pipe_reg[j] <= y_pipe_reg[j-1];
      end
      vld_pipe_reg <= {vld_pipe_reg[K-1:0], is_in_val};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_disp   <= '0;
      out_x      <= '0;
      out_y      <= '0;
      is_out_val <= 1'b0;
`ifdef CENSUS_DISP_COST_OUT_EN
      out_cost   <= '0;
`endif
    end else begin
      out_disp   <= node_idx[1][K-1:0];
      out_x      <= x_pipe_reg[K];
      out_y      <= y_pipe_reg[K];
      is_out_val <= vld_pipe_reg[K];
`ifdef CENSUS_DISP_COST_OUT_EN
      out_cost   <= node_cost[1];
`endif
    end
  end

endmodule

// File: doc/census_disparity.md
Name: census_disparity

Overview:
- Sits directly downstream of the sparse census stage, one census instance per camera.
- Consumes the left and right 8-bit census streams, which advance in lockstep.
- For each left pixel, computes the Hamming cost against NUM_DISP right-image candidates (x-d, d = 0..NUM_DISP-1) and outputs the winner-take-all disparity with its pixel coordinates.
- Fully pipelined, one pixel per valid cycle, no backpressure, matching the upstream streaming style.

Parameters:
- NUM_DISP, 16, number of disparity candidates; power of two, 2..64.
- ROW_SZ, 320, pixels per row; sizes coordinate checks only.
- COL_SZ, 240, rows per frame; passed through for coordinate range only.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_l_val  in  8  left census code
- in_r_val  in  8  right census code for the same (x,y)
- in_x  in  10  column of the current pixel pair
- in_y  in  10  row of the current pixel pair
- is_in_val  in  1  both codes and coordinates valid this cycle
- out_disp  out  $clog2(NUM_DISP)  winning disparity
- out_x  out  10  column of out_disp
- out_y  out  10  row of out_disp
- is_out_val  out  1  output valid, one-cycle strobe per pixel
- out_cost  out  4  minimum cost; present only with CENSUS_DISP_COST_OUT_EN

Behaviour:
- Reset (async assert, sync release): all outputs 0; every pipeline valid bit cleared; right-code window cleared to 0.
- Right window:
  - NUM_DISP x 8-bit shift register; entry d holds the right code at x-d.
  - Entry 0 is the current in_r_val, combinational.
  - Shifts only when is_in_val=1.
- Stage C (cost), registered on every clk:
  - cost_d = popcount(in_l_val XOR win[d]), 4 bits, range 0..8.
  - If d > in_x, cost_d = 15 (masked). This covers row start and the post-reset window fill.
  - Captures x, y and valid.
- Stages M1..Mk, k = $clog2(NUM_DISP):
  - Binary min tree, one registered level per stage.
  - Each node carries the pair (cost, idx).
  - Strict less-than; ties keep the lower idx, so equal costs resolve to the smaller disparity.
  - x, y and valid ride alongside.
- Output register: out_disp = idx, out_x, out_y, is_out_val.
- Latency: exactly L = k + 2 clk cycles from an is_in_val=1 edge to the matching is_out_val=1. Pipeline advances every clock regardless of valid; gaps in is_in_val appear as identical gaps at the output.
- Data registers with valid=0 may hold stale values; outputs other than is_out_val are don't-care when is_out_val=0, except after reset, where they read 0.
- Row wrap: in_x returning to 0 needs no special action; the masking rule rejects candidates from the previous row.
- Frame wrap: no state depends on y; passed through only.
- Reset mid-stream: in-flight pixels are discarded, with no is_out_val for them after release. First output after release is for the first post-reset is_in_val pixel, L cycles later.
- Inputs out of range (in_x >= ROW_SZ): processed as-is, no error.

Optional Feature:
- Macro CENSUS_DISP_COST_OUT_EN.
- Defined: port out_cost exists, carrying the winning cost (0..8) aligned with out_disp; reset value 0. It equals 15 only if all candidates are masked, which cannot occur because d = 0 is never masked.
- Undefined: port and its pipeline bits are absent; all other behaviour is identical.

Decomposition:
- Shared package stereo_pkg holds:
  - CEN_W = 8, COST_W = 4, COST_MASK = 4'd15, COORD_W = 10.
  - A popcount8 function.
  - The cost/idx pair typedef.
- One sub-module, disp_min2: registered two-input (cost, idx) comparator with tie-to-lower-idx.
- The tree is a generate of disp_min2 instances.

Test Plan:
- Shift by 3: left[x] = (x*37) mod 256, right[x] = left[x+3], 320-pixel row, continuous valid -> out_disp = 3 with out_cost = 0 for every x >= 3.
- Row-start border, same stream -> x=0 gives out_disp = 0; x=1 gives at most 1; x=2 gives at most 2; no candidate with d > x is ever chosen, including on the first pixel after reset.
- Ties: all codes 0x00 -> out_disp = 0 every pixel. Left=0xFF, right alternating 0x0F/0xF0 -> cost 4 everywhere, out_disp = 0.
- Latency and bubbles: is_in_val pattern 1,0,1,1,0,0,1 with NUM_DISP=16 -> is_out_val reproduces the same pattern delayed exactly 6 cycles; out_x/out_y match the input coordinates.
- Async reset: assert reset between clock edges while 5 pixels are in flight -> is_out_val drops to 0 immediately; no stale strobes after release; the next pixel emerges after L cycles.
- Cost port with CENSUS_DISP_COST_OUT_EN: left=0xFF, right all 0x01 -> out_cost = 7, out_disp = 0. Recompile without the macro -> port absent and out_disp unchanged.
